// File: rtl/uart_frame_parser.sv
// uart_frame_parser
// Extracts frames of the form AA 55 CMD LEN payload[LEN] [CHK] from a UART
// byte stream, with an inter-byte timeout that abandons partial frames.
// Define UART_FRAME_CHKSUM_EN to require and verify the trailing CHK byte
// (CHK = CMD + LEN + payload, mod 256). Without it, frames end on the last
// payload byte, or on the LEN byte when LEN is 0.
module uart_frame_parser #(
    parameter int unsigned TIMEOUT_CYC = 500000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [7:0]  Uart_rx_byte,
    input  logic        Uart_rx_done,
    output logic [7:0]  Frame_cmd,
    output logic [3:0]  Frame_len,
    output logic [63:0] Frame_data,
    output logic        Frame_valid,
    output logic        Frame_err,
    output logic [1:0]  Err_code
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR2,
        CMD,
        LEN,
        DATA
`ifdef UART_FRAME_CHKSUM_EN
        , CHK
`endif
    } state_t;

    state_t        state;
    logic [2:0]    cnt;
    logic [TW-1:0] timer;
    logic [7:0]    buf_cmd;
    logic [3:0]    buf_len;
    logic [63:0]   buf_data;
    logic [63:0]   data_ins;
`ifdef UART_FRAME_CHKSUM_EN
    logic [7:0]    sum;
`endif

    // Payload buffer with the incoming byte merged in at slot cnt.
    always_comb begin
        data_ins = buf_data;
        data_ins[{cnt, 3'b000} +: 8] = Uart_rx_byte;
    end

    // Frame FSM, inter-byte timeout and registered outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= IDLE;
            cnt         <= '0;
            timer       <= '0;
            buf_cmd     <= '0;
            buf_len     <= '0;
            buf_data    <= '0;
`ifdef UART_FRAME_CHKSUM_EN
            sum         <= '0;
`endif
            Frame_cmd   <= '0;
            Frame_len   <= '0;
            Frame_data  <= '0;
            Frame_valid <= 1'b0;
            Frame_err   <= 1'b0;
            Err_code    <= '0;
        end else begin
            Frame_valid <= 1'b0;
            Frame_err   <= 1'b0;
            if (Uart_rx_done) begin
                // A byte always wins over a coincident timeout expiry.
                timer <= '0;
                case (state)
                    IDLE: begin
                        if (Uart_rx_byte == 8'hAA) state <= HDR2;
                    end
                    HDR2: begin
                        if (Uart_rx_byte == 8'h55)      state <= CMD;
                        else if (Uart_rx_byte != 8'hAA) state <= IDLE;
                    end
                    CMD: begin
                        buf_cmd  <= Uart_rx_byte;
                        buf_data <= '0;
                        cnt      <= '0;
`ifdef UART_FRAME_CHKSUM_EN
                        sum      <= Uart_rx_byte;
`endif
                        state    <= LEN;
                    end
                    LEN: begin
                        buf_len <= Uart_rx_byte[3:0];
`ifdef UART_FRAME_CHKSUM_EN
                        sum     <= sum + Uart_rx_byte;
`endif
                        if (Uart_rx_byte > 8'd8) begin
                            Frame_err <= 1'b1;
                            Err_code  <= 2'd1;
                            state     <= IDLE;
                        end else if (Uart_rx_byte == 8'd0) begin
`ifdef UART_FRAME_CHKSUM_EN
                            state       <= CHK;
`else
                            Frame_valid <= 1'b1;
                            Frame_cmd   <= buf_cmd;
                            Frame_len   <= '0;
                            Frame_data  <= '0;
                            state       <= IDLE;
`endif
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        buf_data <= data_ins;
                        cnt      <= cnt + 3'd1;
`ifdef UART_FRAME_CHKSUM_EN
                        sum      <= sum + Uart_rx_byte;
`endif
                        if ({1'b0, cnt} == buf_len - 4'd1) begin
`ifdef UART_FRAME_CHKSUM_EN
                            state       <= CHK;
`else
                            Frame_valid <= 1'b1;
                            Frame_cmd   <= buf_cmd;
                            Frame_len   <= buf_len;
                            Frame_data  <= data_ins;
                            state       <= IDLE;
`endif
                        end
                    end
`ifdef UART_FRAME_CHKSUM_EN
                    CHK: begin
                        if (Uart_rx_byte == sum) begin
                            Frame_valid <= 1'b1;
                            Frame_cmd   <= buf_cmd;
                            Frame_len   <= buf_len;
                            Frame_data  <= buf_data;
                        end else begin
                            Frame_err <= 1'b1;
                            Err_code  <= 2'd3;
                        end
                        state <= IDLE;
                    end
`endif
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (timer == T_LAST) begin
                    timer     <= '0;
                    Frame_err <= 1'b1;
                    Err_code  <= 2'd2;
                    state     <= IDLE;
                end else begin
                    timer <= timer + TW'(1);
                end
            end
        end
    end

endmodule
